// File: rtl/cla_seq_pkg.sv
// Shared definitions for the sequential carry-lookahead adder: state
// encoding, default geometry and the 4-bit lookahead carry unit.
package cla_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int WIDTH_DEF = 32;
  localparam int SLICE_DEF = 8;

  // Number of slice passes per operation and the index width (minimum 1).
  function automatic int num_slices(input int width, input int slice);
    return width / slice;
  endfunction

  function automatic int idx_width(input int ns);
    return (ns > 1) ? $clog2(ns) : 1;
  endfunction

  localparam int NS_DEF    = WIDTH_DEF / SLICE_DEF;
  localparam int IDX_W_DEF = (NS_DEF > 1) ? $clog2(NS_DEF) : 1;

  // 4-bit lookahead carry unit: carries into bit positions 0..3.
  function automatic logic [3:0] lcu4_carry(input logic [3:0] p, input logic [3:0] g,
                                            input logic ci);
    logic [3:0] c;
    c[0] = ci;
    c[1] = g[0] | (p[0] & ci);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
    return c;
  endfunction

  // 4-bit lookahead carry unit: group propagate/generate as {pp, gg}.
  function automatic logic [1:0] lcu4_pg(input logic [3:0] p, input logic [3:0] g);
    return {&p, g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])};
  endfunction

endpackage

// File: rtl/cla_seq_adder_slice.sv
// Combinational SLICE-bit carry-lookahead adder built from 4-bit groups
// with a second lookahead level across the group propagate/generate.
module cla_slice
  import cla_seq_pkg::*;
#(
  parameter int SLICE = SLICE_DEF
) (
  input  logic [SLICE-1:0] x,
  input  logic [SLICE-1:0] y,
  input  logic             ci,
  output logic [SLICE-1:0] s,
  output logic             co,
  output logic [SLICE-1:0] c
);

  localparam int NG = SLICE / 4;
  localparam int NL = (NG + 3) / 4;

  logic [SLICE-1:0]  p;
  logic [SLICE-1:0]  g;
  logic [NL*4-1:0]   gp;
  logic [NL*4-1:0]   gg;

  assign p = x ^ y;
  assign g = x & y;

  // Second level: one lookahead unit per four groups, chained when SLICE > 16.
  for (genvar li = 0; li < NL; li++) begin : g_l2
    logic       cin;
    logic [3:0] lc;
    logic [1:0] pg2;
    logic       cout_l;
    logic       unused_l2;
    if (li == 0) begin : g_first
      assign cin = ci;
    end else begin : g_next
      assign cin = g_l2[li-1].cout_l;
    end
    assign lc        = lcu4_carry(gp[4*li +: 4], gg[4*li +: 4], cin);
    assign pg2       = lcu4_pg(gp[4*li +: 4], gg[4*li +: 4]);
    assign cout_l    = pg2[0] | (pg2[1] & cin);
    assign unused_l2 = ^{lc, cout_l};
  end

  // First level: each 4-bit group takes its carry-in from the second level.
  for (genvar gi = 0; gi < NG; gi++) begin : g_grp
    logic [3:0] cc;
    logic [1:0] pg;
    assign cc             = lcu4_carry(p[4*gi +: 4], g[4*gi +: 4], g_l2[gi/4].lc[gi%4]);
    assign pg             = lcu4_pg(p[4*gi +: 4], g[4*gi +: 4]);
    assign c[4*gi +: 4]   = cc;
    assign gp[gi]         = pg[1];
    assign gg[gi]         = pg[0];
  end

  // Unused second-level lanes see neither propagate nor generate.
  if (NL * 4 > NG) begin : g_pad
    assign gp[NL*4-1:NG] = '0;
    assign gg[NL*4-1:NG] = '0;
  end

  if (NG % 4 == 0) begin : g_co_full
    assign co = g_l2[NL-1].cout_l;
  end else begin : g_co_part
    assign co = g_l2[NL-1].lc[NG%4];
  end

  assign s = p ^ c;

endmodule

// File: rtl/cla_seq_adder.sv
// Multi-cycle WIDTH-bit add/subtract that reuses one SLICE-bit CLA slice,
// least-significant slice first, with valid/ready on both sides.
module cla_seq_adder
  import cla_seq_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int SLICE = SLICE_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int NS    = num_slices(WIDTH, SLICE);
  localparam int IDX_W = idx_width(NS);

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic             carry;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] sum_nx;
  logic [SLICE-1:0] s_sl;
  logic [SLICE-1:0] c_sl;
  logic             co_sl;
  logic             last;

  cla_slice #(.SLICE(SLICE)) u_slice (
    .x  (a_q[int'(idx)*SLICE +: SLICE]),
    .y  (b_q[int'(idx)*SLICE +: SLICE]),
    .ci (carry),
    .s  (s_sl),
    .co (co_sl),
    .c  (c_sl)
  );

  assign last      = (idx == IDX_W'(NS - 1));
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  // Merge the current slice result into the running sum.
  always_comb begin
    sum_nx = sum;
    sum_nx[int'(idx)*SLICE +: SLICE] = s_sl;
  end

  // Operand capture; subtraction stored as the one's complement of B.
  always_ff @(posedge clk) begin
    if (state == IDLE && in_valid) begin
      a_q <= a;
      b_q <= b ^ {WIDTH{sub}};
    end
  end

  // Sequencer: slice index, carry chain, result and flag registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      idx   <= '0;
      carry <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
      zero  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            carry <= sub;
            idx   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          sum   <= sum_nx;
          carry <= co_sl;
          idx   <= idx + IDX_W'(1);
          if (last) begin
            cout  <= co_sl;
            ovf   <= c_sl[SLICE-1] ^ co_sl;
            zero  <= (sum_nx == '0);
            state <= DONE;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cla_seq_adder.sv
// Scoreboard bench for cla_seq_adder at default geometry (32-bit, 8-bit slice).
module tb_cla_seq_adder;

  typedef struct packed {
    logic [31:0] s;
    logic        c;
    logic        o;
    logic        z;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        sub = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] sum;
  logic        cout;
  logic        ovf;
  logic        zero;

  int   n_cmp = 0;
  int   n_err = 0;
  exp_t sb[$];

  cla_seq_adder dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .zero      (zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Independent 33-bit reference for add/sub with flags.
  function automatic exp_t model(input logic [31:0] ai, input logic [31:0] bi, input logic si);
    exp_t        e;
    logic [31:0] bx;
    logic [32:0] full;
    bx   = bi ^ {32{si}};
    full = {1'b0, ai} + {1'b0, bx} + 33'(si);
    e.s  = full[31:0];
    e.c  = full[32];
    e.o  = (ai[31] == bx[31]) && (full[31] != ai[31]);
    e.z  = (full[31:0] == 32'h0);
    return e;
  endfunction

  task automatic check_reset_vals(input string tag);
    chk({tag, "_sum"}, sum, 0);
    chk({tag, "_cout"}, cout, 0);
    chk({tag, "_ovf"}, ovf, 0);
    chk({tag, "_zero"}, zero, 0);
    chk({tag, "_ovld"}, out_valid, 0);
    chk({tag, "_irdy"}, in_ready, 1);
  endtask

  task automatic run_op(input logic [31:0] ai, input logic [31:0] bi, input logic si,
                        input int hold, input bit poke);
    int   n;
    exp_t e;
    n = 0;
    while (!in_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    chk("in_ready_idle", in_ready, 1);
    a = ai; b = bi; sub = si; in_valid = 1'b1;
    @(posedge clk);
    sb.push_back(model(ai, bi, si));
    #1 in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin
      if (poke && n < 3) begin
        in_valid = 1'b1; a = $urandom; b = $urandom; sub = 1'($urandom_range(0, 1));
      end else begin
        in_valid = 1'b0;
      end
      @(posedge clk); #1; n++;
      if (!out_valid) chk("in_ready_run", in_ready, 0);
    end
    in_valid = 1'b0;
    chk("latency", n, 4);
    chk("sb_depth", sb.size(), 1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("sum", sum, e.s);
      chk("cout", cout, e.c);
      chk("ovf", ovf, e.o);
      chk("zero", zero, e.z);
      for (int i = 0; i < hold; i++) begin
        out_ready = 1'b0;
        @(posedge clk); #1;
        chk("hold_ovld", out_valid, 1);
        chk("hold_irdy", in_ready, 0);
        chk("hold_sum", sum, e.s);
        chk("hold_flags", {cout, ovf, zero}, {e.c, e.o, e.z});
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk("ovld_drop", out_valid, 0);
      chk("irdy_back", in_ready, 1);
      chk("sum_kept", sum, e.s);
    end
  endtask

  initial begin
    int n;
    #2;
    check_reset_vals("rst0");
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    check_reset_vals("post_rst");

    run_op(32'h000000FF, 32'h00000001, 1'b0, 0, 1'b0);
    run_op(32'hFFFFFFFF, 32'h00000001, 1'b0, 0, 1'b0);
    run_op(32'h7FFFFFFF, 32'h00000001, 1'b0, 0, 1'b0);
    run_op(32'h00000005, 32'h00000007, 1'b1, 0, 1'b0);
    run_op(32'h80000000, 32'h00000001, 1'b1, 3, 1'b0);
    run_op(32'h12345678, 32'h11111111, 1'b0, 0, 1'b1);
    run_op(32'h00000009, 32'h00000009, 1'b1, 1, 1'b0);
    for (int i = 0; i < 6; i++)
      run_op($urandom, $urandom, 1'($urandom_range(0, 1)), i % 2, 1'(i % 3 == 0));

    // Reset while the third slice is being processed.
    a = 32'h12345678; b = 32'h0FEDCBA9; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    @(posedge clk); @(posedge clk); #1 rst = 1'b1;
    #1 check_reset_vals("mid_rst");
    @(posedge clk); #1 rst = 1'b0;
    n = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (out_valid) n++;
    end
    chk("no_ovld_after_rst", n, 0);
    run_op(32'h00000003, 32'h00000004, 1'b0, 0, 1'b0);

    chk("sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/cla_seq_adder.md
Name: cla_seq_adder

Overview:
- Multi-cycle sequencer that performs a WIDTH-bit add/subtract by reusing one narrow SLICE-bit carry-lookahead slice over WIDTH/SLICE cycles, least-significant slice first.
- Serves as the area-reduced adder option for the KGP-RISC ALU.
- Carry out of each slice is registered and fed back as the next slice's carry-in.
- Valid/ready handshake on both input and output.

Parameters:
- WIDTH, 32: operand/result width; must be a multiple of SLICE.
- SLICE, 8: width of the reused CLA slice; must be a multiple of 4.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  operands and op valid
- in_ready  out  1  block can accept a new operation
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- sub  in  1  1 = compute A-B, 0 = compute A+B
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- sum  out  WIDTH  result
- cout  out  1  carry out of MSB (sub: 1 = no borrow)
- ovf  out  1  signed overflow
- zero  out  1  sum == 0

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
- Reset values: state=IDLE, idx=0, carry=0, sum=0, cout=0, ovf=0, zero=0, out_valid=0, in_ready=1.
- NS = WIDTH/SLICE. idx counter is ceil(log2(NS)) bits, minimum 1.
- FSM states and transitions:
  - IDLE: in_ready=1. If in_valid is high at a clock edge, capture a, b XOR {WIDTH{sub}} and carry=sub; clear idx; go to RUN.
  - RUN: in_ready=0. Each cycle the slice computes bits [idx*SLICE +: SLICE] from the captured operands and carry, and that result field is written into sum. Set carry <= slice carry-out and idx <= idx+1. When idx==NS-1, also register cout = slice carry-out, ovf = (carry into MSB) XOR (carry out of MSB) taken from the slice's internal carry vector, and zero = (full next sum == 0). Then go to DONE.
  - DONE: out_valid=1, in_ready=0. If out_ready is high at a clock edge, go to IDLE.
- Latency: with input accepted at edge T0, out_valid is high after edge T0+NS (4 cycles at defaults). Throughput is one operation per NS+2 cycles.
- Backpressure: while out_valid=1 and out_ready=0, sum, cout, ovf and zero are held stable.
- Result registers keep the last value after the output handshake until the next accept. Bits of sum not yet written in RUN keep their previous values; out_valid is low during RUN.
- in_valid during RUN or DONE is ignored, and the input is not captured.
- out_ready outside DONE has no effect.
- Reset asserted mid-RUN or in DONE: immediate return to the reset values and the operation is dropped; no out_valid follows.
- No combinational path from in_valid to out_valid or from out_ready to in_ready; in_ready and out_valid are decoded from the state register only.

Decomposition:
- Shared package cla_seq_pkg holds:
  - state enum {IDLE, RUN, DONE}
  - default constants WIDTH=32, SLICE=8
  - localparam derivation of NS and the index width
- Sub-module cla_slice: purely combinational SLICE-bit CLA, composed of SLICE/4 4-bit groups. Each group uses the existing 4-bit lookahead carry unit for its p/g/c. A second-level lookahead carry unit combines the group PP/GG.
  - Inputs: x, y, ci.
  - Outputs: s, co, and the internal carry vector c[SLICE-1:0] (needed for the ovf tap).
- The sequencer instantiates one cla_slice.

Test Plan:
- Add 0x000000FF + 0x00000001 -> sum=0x00000100, cout=0, ovf=0, zero=0; carry propagates across the slice boundary; out_valid is high exactly 4 cycles after accept.
- Add 0xFFFFFFFF + 0x00000001 -> sum=0x00000000, cout=1, ovf=0, zero=1.
- Add 0x7FFFFFFF + 0x00000001 -> sum=0x80000000, cout=0, ovf=1.
- Sub 0x00000005 - 0x00000007 -> sum=0xFFFFFFFE, cout=0, ovf=0. Sub 0x80000000 - 0x00000001 -> sum=0x7FFFFFFF, cout=1, ovf=1.
- Backpressure and illegal input: hold out_ready=0 for 3 cycles in DONE -> sum, cout, ovf and zero stay constant and in_ready=0. Toggle in_valid with new operands during RUN -> they are not captured and the result is unchanged.
- Assert rst for 1 cycle at idx=2 of an add -> all outputs go to reset values asynchronously with in_ready=1 and no out_valid. A new add 0x00000003 + 0x00000004 then completes with sum=0x00000007.
